io_controller: RTL and testbench

- Responder side of the CPU's I/O strobe interface: decodes io_* strobes issued by the instruction sequencer, moves data between the shared 16-bit d_bus and up to 16 external device ports, and hosts the interrupt controller.
- Interrupt controller functions: edge capture, pending bitmap, priority select, vector generation, return-address storage.
- Sits beside the register file, logic unit and PC on d_bus. Drives the bus only when one of its push strobes is active.

---
 rtl/io_pkg.sv | 28 ++
 rtl/irq_capture.sv | 41 ++++
 rtl/io_controller.sv | 96 +++++++++
 tb/tb_io_controller.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared widths, defaults and the interrupt priority encoder for the I/O controller.
package io_pkg;

  localparam int unsigned IO_DATA_W = 16;
  localparam int unsigned IO_ADDR_W = 4;
  localparam int unsigned MAX_IRQ   = 16;

  localparam logic [IO_DATA_W-1:0] VECTOR_BASE_DEFAULT = 16'h0010;

  typedef struct packed {
    logic                 valid;
    logic [IO_ADDR_W-1:0] index;
  } prio_t;

  // Lowest-indexed set bit wins; index is 0 when nothing is set.
  function automatic prio_t prio_encode(input logic [MAX_IRQ-1:0] req);
    prio_t r;
    r = '0;
    for (int i = int'(MAX_IRQ) - 1; i >= 0; i--) begin
      if (req[i]) begin
        r.valid = 1'b1;
        r.index = IO_ADDR_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_capture.sv
// Per-line interrupt synchronizer, rising-edge detect and pending bitmap.
module irq_capture
  import io_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_IRQ-1:0]   irq_i,
  input  logic                 ack_valid_i,
  input  logic [IO_ADDR_W-1:0] ack_index_i,
  output logic [NUM_IRQ-1:0]   pending_o
);

  logic [NUM_IRQ-1:0] sync1_q, sync2_q, prev_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] rise, clr;

  assign rise = sync2_q & ~prev_q;
  assign clr  = ack_valid_i ? (NUM_IRQ'(1) << ack_index_i) : '0;

  // A fresh edge on the bit being acknowledged keeps it pending.
  assign pending_d = (pending_q & ~clr) | rise;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      pending_q <= '0;
    end else begin
      sync1_q   <= irq_i;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/io_controller.sv
// I/O strobe responder: device port read/write, return-address store and interrupt vectoring.
module io_controller
  import io_pkg::*;
#(
  parameter int unsigned          NUM_IRQ     = 8,
  parameter logic [IO_DATA_W-1:0] VECTOR_BASE = VECTOR_BASE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 io_read,
  input  logic                 io_write,
  input  logic                 io_push,
  input  logic                 io_addr_read,
  input  logic [IO_ADDR_W-1:0] io_addr,
  input  logic                 io_store_retaddr,
  input  logic                 io_push_retaddr,
  input  logic                 io_push_ints,
  input  logic                 io_push_int_addr,
  output logic                 io_interrupt,
  inout  wire  [IO_DATA_W-1:0] d_bus,
  output logic [IO_ADDR_W-1:0] port_addr,
  output logic                 port_rd,
  output logic                 port_wr,
  output logic [IO_DATA_W-1:0] port_wdata,
  input  logic [IO_DATA_W-1:0] port_rdata,
  input  logic [NUM_IRQ-1:0]   irq_in
);

  logic [IO_ADDR_W-1:0] addr_q;
  logic [IO_DATA_W-1:0] rdata_q, retaddr_q, vec_q, vec_d;
  logic                 vec_drive_q;
  logic [NUM_IRQ-1:0]   pending;
  prio_t                ack_sel;
  logic                 ack_valid;
  logic                 drive_en;
  logic [IO_DATA_W-1:0] drive_data;

  irq_capture #(
    .NUM_IRQ(NUM_IRQ)
  ) u_irq_capture (
    .clk_i      (clk),
    .rst_i      (rst),
    .irq_i      (irq_in),
    .ack_valid_i(ack_valid),
    .ack_index_i(ack_sel.index),
    .pending_o  (pending)
  );

  assign ack_sel   = prio_encode(MAX_IRQ'(pending));
  assign ack_valid = io_push_int_addr & ack_sel.valid;
  assign vec_d     = VECTOR_BASE + IO_DATA_W'(ack_sel.index);

  assign port_addr    = io_addr_read ? io_addr : addr_q;
  assign port_rd      = io_read & ~rst;
  assign port_wr      = io_write & ~rst;
  assign port_wdata   = d_bus;
  assign io_interrupt = |pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      rdata_q     <= '0;
      retaddr_q   <= '0;
      vec_q       <= '0;
      vec_drive_q <= 1'b0;
    end else begin
      if (io_addr_read)     addr_q    <= io_addr;
      if (io_read)          rdata_q   <= port_rdata;
      if (io_store_retaddr) retaddr_q <= d_bus;
      if (io_push_int_addr) vec_q     <= vec_d;
      vec_drive_q <= io_push_int_addr;
    end
  end

  // Fixed priority keeps a single source on the bus even if the sequencer misbehaves.
  always_comb begin
    drive_en   = 1'b0;
    drive_data = rdata_q;
    if (io_push_retaddr) begin
      drive_en   = 1'b1;
      drive_data = retaddr_q;
    end else if (vec_drive_q) begin
      drive_en   = 1'b1;
      drive_data = vec_q;
    end else if (io_push_ints) begin
      drive_en   = 1'b1;
      drive_data = IO_DATA_W'(pending);
    end else if (io_push) begin
      drive_en   = 1'b1;
      drive_data = rdata_q;
    end
  end

  assign d_bus = (drive_en && !rst) ? drive_data : 'z;

endmodule

// File: tb/tb_io_controller.sv
// Self-checking bench for io_controller: vector table, directed corner sequences, random traffic.
module tb_io_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_read, io_write, io_push, io_addr_read;
  logic [3:0]  io_addr;
  logic        io_store_retaddr, io_push_retaddr, io_push_ints, io_push_int_addr;
  logic        io_interrupt;
  wire  [15:0] d_bus;
  logic [3:0]  port_addr;
  logic        port_rd, port_wr;
  logic [15:0] port_wdata, port_rdata;
  logic [7:0]  irq_in;
  logic        tb_bus_en;
  logic [15:0] tb_bus;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [3:0]  m_addr;
  logic [15:0] m_rdata, m_ret, m_vec;
  logic        m_vecflag;
  logic [7:0]  m_pend;
  logic [7:0]  samp [3];
  logic [15:0] exp_bus, bus_val;
  logic        exp_drv;

  assign d_bus = tb_bus_en ? tb_bus : 16'hzzzz;

  always #5 clk = ~clk;

  io_controller dut (
    .clk             (clk),
    .rst             (rst),
    .io_read         (io_read),
    .io_write        (io_write),
    .io_push         (io_push),
    .io_addr_read    (io_addr_read),
    .io_addr         (io_addr),
    .io_store_retaddr(io_store_retaddr),
    .io_push_retaddr (io_push_retaddr),
    .io_push_ints    (io_push_ints),
    .io_push_int_addr(io_push_int_addr),
    .io_interrupt    (io_interrupt),
    .d_bus           (d_bus),
    .port_addr       (port_addr),
    .port_rd         (port_rd),
    .port_wr         (port_wr),
    .port_wdata      (port_wdata),
    .port_rdata      (port_rdata),
    .irq_in          (irq_in)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clr_in();
    io_read = 0; io_write = 0; io_push = 0; io_addr_read = 0; io_addr = 0;
    io_store_retaddr = 0; io_push_retaddr = 0; io_push_ints = 0; io_push_int_addr = 0;
    tb_bus_en = 0; tb_bus = 0;
  endtask

  task automatic model_reset();
    m_addr = 0; m_rdata = 0; m_ret = 0; m_vec = 0; m_vecflag = 0; m_pend = 0;
    for (int i = 0; i < 3; i++) samp[i] = 0;
  endtask

  // Let inputs settle mid-cycle, then compare combinational outputs with the model.
  task automatic settle_check();
    int drv;
    #4;
    drv = int'(tb_bus_en) + int'(io_push) + int'(io_push_retaddr) + int'(io_push_ints)
        + int'(m_vecflag);
    assert (drv <= 1) else $error("bus contention: %0d drivers", drv);
    exp_drv = 1'b1;
    if (io_push_retaddr)   exp_bus = m_ret;
    else if (m_vecflag)    exp_bus = m_vec;
    else if (io_push_ints) exp_bus = {8'h00, m_pend};
    else if (io_push)      exp_bus = m_rdata;
    else begin
      exp_drv = 1'b0;
      exp_bus = 16'h0;
    end
    bus_val = exp_drv ? exp_bus : (tb_bus_en ? tb_bus : 16'h0);
    chk("port_addr", port_addr, io_addr_read ? io_addr : m_addr);
    chk("port_rd", port_rd, io_read);
    chk("port_wr", port_wr, io_write);
    chk("io_interrupt", io_interrupt, |m_pend);
    if (io_write) chk("port_wdata", port_wdata, bus_val);
    if (exp_drv)  chk("d_bus", d_bus, exp_bus);
  endtask

  // Apply the clock edge to the model, then to the DUT.
  task automatic advance();
    logic [7:0] rise;
    int         k;
    bit         found;
    rise  = samp[1] & ~samp[2];
    k     = 0;
    found = 0;
    for (int i = 7; i >= 0; i--) if (m_pend[i]) begin k = i; found = 1; end
    if (io_addr_read)     m_addr  = io_addr;
    if (io_read)          m_rdata = port_rdata;
    if (io_store_retaddr) m_ret   = bus_val;
    if (io_push_int_addr) begin
      if (found) m_pend[k] = 1'b0;
      m_vec = 16'h0010 + 16'(k);
    end
    m_pend    = m_pend | rise;
    m_vecflag = io_push_int_addr;
    samp[2]   = samp[1];
    samp[1]   = samp[0];
    samp[0]   = irq_in;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    settle_check();
    advance();
  endtask

  // Reset asserted between edges with the current command still presented.
  task automatic do_reset();
    rst = 1;
    #4;
    chk("rst_port_rd", port_rd, 1'b0);
    chk("rst_port_wr", port_wr, 1'b0);
    chk("rst_io_interrupt", io_interrupt, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    clr_in();
  endtask

  typedef struct packed {
    logic        ar;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic        push;
    logic [15:0] data;
    logic [3:0]  exp_pa;
    logic        exp_rd;
    logic        exp_wr;
    logic [15:0] exp_bus;
  } vec_t;

  vec_t vtab [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; clr_in(); irq_in = 0; port_rdata = 0; model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    // Reset state: nothing pending, read-data register empty
    settle_check();
    chk("reset_irq", io_interrupt, 1'b0);
    chk("reset_port_addr", port_addr, 4'h0);
    advance();
    io_push = 1;
    settle_check();
    chk("reset_push", d_bus, 16'h0000);
    advance();
    clr_in();

    //                ar addr rd wr pu data      pa rd wr bus
    vtab[0] = '{1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 16'hBEEF, 4'h3, 1'b1, 1'b0, 16'h0000};
    vtab[1] = '{1'b0, 4'h7, 1'b0, 1'b0, 1'b1, 16'h0000, 4'h3, 1'b0, 1'b0, 16'hBEEF};
    vtab[2] = '{1'b0, 4'h7, 1'b0, 1'b0, 1'b1, 16'h0000, 4'h3, 1'b0, 1'b0, 16'hBEEF};
    vtab[3] = '{1'b1, 4'h9, 1'b0, 1'b1, 1'b0, 16'h1234, 4'h9, 1'b0, 1'b1, 16'h1234};
    vtab[4] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h9, 1'b0, 1'b0, 16'h0000};
    vtab[5] = '{1'b0, 4'h5, 1'b0, 1'b1, 1'b0, 16'hA5A5, 4'h9, 1'b0, 1'b1, 16'hA5A5};
    vtab[6] = '{1'b0, 4'h5, 1'b1, 1'b0, 1'b0, 16'h0F0F, 4'h9, 1'b1, 1'b0, 16'h0000};
    vtab[7] = '{1'b1, 4'hC, 1'b0, 1'b0, 1'b1, 16'h0000, 4'hC, 1'b0, 1'b0, 16'h0F0F};
    for (int i = 0; i < 8; i++) begin
      clr_in();
      io_addr_read = vtab[i].ar;
      io_addr      = vtab[i].addr;
      io_read      = vtab[i].rd;
      io_write     = vtab[i].wr;
      io_push      = vtab[i].push;
      port_rdata   = vtab[i].rd ? vtab[i].data : 16'(($urandom));
      tb_bus_en    = vtab[i].wr;
      tb_bus       = vtab[i].data;
      settle_check();
      chk($sformatf("tab%0d_addr", i), port_addr, vtab[i].exp_pa);
      chk($sformatf("tab%0d_rd", i), port_rd, vtab[i].exp_rd);
      chk($sformatf("tab%0d_wr", i), port_wr, vtab[i].exp_wr);
      if (vtab[i].wr)   chk($sformatf("tab%0d_wdata", i), port_wdata, vtab[i].exp_bus);
      if (vtab[i].push) chk($sformatf("tab%0d_bus", i), d_bus, vtab[i].exp_bus);
      advance();
    end
    clr_in();

    // Reset in the middle of a read, with an interrupt pending
    irq_in = 8'h01;
    cycle();
    irq_in = 8'h00;
    repeat (3) cycle();
    chk("pre_rst_irq", io_interrupt, 1'b1);
    io_read = 1; port_rdata = 16'hCAFE;
    cycle();
    do_reset();
    io_push = 1;
    settle_check();
    chk("post_rst_push", d_bus, 16'h0000);
    advance();
    clr_in();

    // Two simultaneous requests, 3-edge latency, acknowledged lowest first
    irq_in = 8'h24;
    cycle();
    irq_in = 8'h00;
    settle_check();
    chk("irq_lat_e1", io_interrupt, 1'b0);
    advance();
    settle_check();
    chk("irq_lat_e2", io_interrupt, 1'b0);
    advance();
    settle_check();
    chk("irq_lat_e3", io_interrupt, 1'b1);
    io_push_ints = 1;
    settle_check();
    chk("ints_24", d_bus, 16'h0024);
    advance();
    clr_in();
    io_push_int_addr = 1;
    cycle();
    clr_in();
    settle_check();
    chk("vec_12", d_bus, 16'h0012);
    advance();
    io_push_ints = 1;
    settle_check();
    chk("ints_20", d_bus, 16'h0020);
    advance();
    clr_in();
    io_push_int_addr = 1;
    cycle();
    clr_in();
    settle_check();
    chk("vec_15", d_bus, 16'h0015);
    chk("irq_clear", io_interrupt, 1'b0);
    advance();

    // Return address stored alongside a spurious acknowledge
    tb_bus_en = 1; tb_bus = 16'h00A7; io_store_retaddr = 1; io_push_int_addr = 1;
    cycle();
    clr_in();
    settle_check();
    chk("vec_spurious", d_bus, 16'h0010);
    advance();
    io_push_retaddr = 1;
    settle_check();
    chk("retaddr", d_bus, 16'h00A7);
    advance();
    clr_in();

    // New edge on irq 1 lands on the edge that acknowledges it
    irq_in = 8'h02;
    cycle();
    irq_in = 8'h00;
    repeat (3) cycle();
    chk("irq1_pend", io_interrupt, 1'b1);
    irq_in = 8'h02;
    cycle();
    cycle();
    io_push_int_addr = 1;
    cycle();
    clr_in();
    settle_check();
    chk("vec_11", d_bus, 16'h0011);
    chk("irq1_kept", io_interrupt, 1'b1);
    advance();
    io_push_ints = 1;
    settle_check();
    chk("ints_02", d_bus, 16'h0002);
    advance();
    clr_in();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      int op;
      clr_in();
      io_addr    = 4'($urandom_range(0, 15));
      port_rdata = 16'($urandom);
      tb_bus     = 16'($urandom);
      if ($urandom_range(0, 7) == 0) irq_in[$urandom_range(0, 7)] ^= 1'b1;
      op = $urandom_range(0, 10);
      if (m_vecflag && (op >= 3) && (op != 9)) op = 0;
      case (op)
        1: begin io_addr_read = 1; io_read = 1; end
        2: io_read = 1;
        3: io_push = 1;
        4: begin io_addr_read = 1; io_write = 1; tb_bus_en = 1; end
        5: begin io_write = 1; tb_bus_en = 1; end
        6: begin io_store_retaddr = 1; tb_bus_en = 1; end
        7: io_push_retaddr = 1;
        8: io_push_ints = 1;
        9: io_push_int_addr = 1;
        10: begin io_push_int_addr = 1; io_store_retaddr = 1; tb_bus_en = 1; end
        default: ;
      endcase
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
